// File: rtl/dsp_imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_imem_loader_pkg
// Description : Shared widths and the NOP instruction word for the DSP
//               instruction-memory loader and its store.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp_imem_loader_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] NOP_WORD = '0;

endpackage
`default_nettype wire

// File: rtl/dsp_imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : dsp_imem_loader_if
// Description : Fetch port and host program-load port of the instruction
//               memory loader. master = core/host side, slave = loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface dsp_imem_loader_if #(
    parameter int ADDR_W = dsp_imem_loader_pkg::ADDR_W,
    parameter int DATA_W = dsp_imem_loader_pkg::DATA_W
);

    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_hold;
    logic              ld_start;
    logic [ADDR_W:0]   ld_len;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              ld_busy;
    logic              ld_done;
    logic              ld_err;

    modport master (
        output fetch_addr, ld_start, ld_len, ld_valid, ld_data,
        input  fetch_data, fetch_hold, ld_ready, ld_busy, ld_done, ld_err
    );

    modport slave (
        input  fetch_addr, ld_start, ld_len, ld_valid, ld_data,
        output fetch_data, fetch_hold, ld_ready, ld_busy, ld_done, ld_err
    );

endinterface
`default_nettype wire

// File: rtl/dsp_imem_ram.sv
`default_nettype none
// ============================================================================
// Module      : dsp_imem_ram
// Description : Simple dual-port program store: one synchronous write port,
//               one registered read port with read-enable. Not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_imem_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic              i_re,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output logic      [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port, holds its value when not enabled
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dsp_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : dsp_imem_loader
// Description : Instruction-memory responder for the DSP fetch stage. Serves
//               fetch reads from the program store and streams host program
//               loads into it, holding the core and returning NOP meanwhile.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_imem_loader
    import dsp_imem_loader_pkg::*;
#(
    parameter int ADDR_W = dsp_imem_loader_pkg::ADDR_W,
    parameter int DATA_W = dsp_imem_loader_pkg::DATA_W
) (
    input  wire logic    clk,
    input  wire logic    rst,
    dsp_imem_loader_if.slave bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_ONE   = (ADDR_W+1)'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_err;
    logic              r_rd_valid;
    logic              w_ready;
    logic              w_busy;
    logic              w_done;
    logic              w_beat;
    logic              w_we;
    logic              w_re;
    logic [DATA_W-1:0] w_rd_data;

    assign w_beat = bus.ld_valid & w_ready;
    // A reset edge must not commit a beat presented alongside it
    assign w_we   = w_beat & ~rst;
    // Read only when idle now and staying idle, so fetch_data is NOP for the
    // whole time fetch_hold is high, including the cycle right after ld_start
    assign w_re   = (r_state == c_IDLE) && (w_state_nxt == c_IDLE) && !rst;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.ld_start) begin
                    if (bus.ld_len == '0) begin
                        w_state_nxt = c_DONE;
                    end else if (bus.ld_len <= c_DEPTH) begin
                        w_state_nxt = c_LOAD;
                    end
                end
            end
            c_LOAD: begin
                if (w_beat && (r_remaining == c_ONE)) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state
    always_comb begin
        w_ready = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            c_LOAD: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
            end
            c_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Write pointer, remaining-word counter and sticky length error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_remaining <= '0;
            r_err       <= 1'b0;
        end else if ((r_state == c_IDLE) && bus.ld_start) begin
            if (bus.ld_len > c_DEPTH) begin
                r_err <= 1'b1;
            end else begin
                r_err       <= 1'b0;
                r_wr_ptr    <= '0;
                r_remaining <= bus.ld_len;
            end
        end else if (w_beat) begin
            r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);
            r_remaining <= r_remaining - c_ONE;
        end
    end

    // Marks whether the RAM output register holds a real fetch result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_re;
        end
    end

    dsp_imem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.ld_data),
        .i_re    (w_re),
        .i_raddr (bus.fetch_addr),
        .o_rdata (w_rd_data)
    );

    assign bus.fetch_data = r_rd_valid ? w_rd_data : NOP_WORD;
    assign bus.fetch_hold = w_busy;
    assign bus.ld_busy    = w_busy;
    assign bus.ld_ready   = w_ready;
    assign bus.ld_done    = w_done;
    assign bus.ld_err     = r_err;

endmodule
`default_nettype wire

// File: doc/dsp_imem_loader.md
# dsp_imem_loader

Instruction-memory responder for the DSP fetch stage: it answers the fetch stage's address with an instruction word and owns the program store behind it. A host-side load port streams a program into the store under a valid/ready handshake. While a load is in progress, the core is held and the fetch port returns NOP.

## Interface
Parameters:
- ADDR_W, 10: instruction address width; store depth is 2^ADDR_W words.
- DATA_W, 32: instruction word width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- fetch_addr  in  ADDR_W  fetch stage program-counter address
- fetch_data  out  DATA_W  registered instruction word for fetch_addr
- fetch_hold  out  1  high while a load is in progress; the core must stall or stay in reset
- ld_start  in  1  single-cycle request to begin a program load
- ld_len  in  ADDR_W+1  word count, sampled with ld_start
- ld_valid  in  1  host data beat valid
- ld_data  in  DATA_W  host data beat
- ld_ready  out  1  loader accepts a beat
- ld_busy  out  1  load in progress
- ld_done  out  1  single-cycle pulse: load completed
- ld_err  out  1  sticky: rejected ld_len

## Operation
- State machine with three states: IDLE, LOAD, DONE.
- IDLE:
  - ld_start with 0 < ld_len ≤ 2^ADDR_W: latch ld_len into a remaining counter, clear the write pointer, clear ld_err, go to LOAD.
  - ld_start with ld_len == 0: go to DONE with no writes; clear ld_err.
  - ld_start with ld_len > 2^ADDR_W: set ld_err, stay in IDLE, memory untouched.
- LOAD:
  - ld_ready = 1. A beat is accepted when ld_valid & ld_ready; it writes ld_data at the write pointer, then the pointer increments and remaining decrements.
  - Acceptance of the final beat (remaining == 1) goes to DONE.
  - ld_start is ignored in LOAD.
- DONE: lasts exactly one cycle with ld_done = 1, then returns to IDLE.
- fetch_hold = ld_busy = (state != IDLE).
- Fetch:
  - In IDLE, fetch_data <= mem[fetch_addr] every cycle.
  - In LOAD and DONE, fetch_data <= NOP_WORD (all zeros).
- The write pointer is ADDR_W wide. A full-depth load ends with the pointer wrapped to 0; no write goes out of range.
- rst:
  - state → IDLE; fetch_data = 0, ld_ready = 0, ld_busy = 0, fetch_hold = 0, ld_done = 0, ld_err = 0; pointer and counter → 0.
  - Memory contents are not cleared.
  - Reset mid-load abandons the load with no ld_done. Words already written remain.

## Timing
- Fetch latency is 1 cycle: fetch_addr sampled at edge N appears on fetch_data after edge N.
- ld_start at edge N → LOAD after edge N; ld_ready first high in cycle N+1.
- Throughput is one beat per cycle. ld_valid may drop between beats with no penalty.
- Final beat accepted at edge M → ld_done high in cycle M+1 (DONE), fetch_hold low from cycle M+2.
- ld_len == 0: ld_done high in the cycle after ld_start.
- ld_err rises the cycle after the rejected ld_start.
- The first real fetch_data after a load is valid 1 cycle after fetch_hold falls. The core should release from hold with PC = 0.
- Write and read never target the store in the same cycle, because reads are suppressed outside IDLE. No read-during-write rule is needed.

## Structure
- The widths ADDR_W/DATA_W (matching the shared memory-address and instruction-word lengths) and NOP_WORD belong in the shared definitions file. The state encodings are local constants.
- One sub-module: dsp_imem_ram, a simple dual-port store with one synchronous write port, one synchronous registered read port and a read-enable. The FSM, counters and handshake live in dsp_imem_loader.

## Test plan
- Reset then idle: rst for 2 cycles → all outputs 0. Release with fetch_addr = 5 → fetch_data = mem[5] one cycle later.
- Basic load: ld_start, ld_len = 4, beats 0xA0..0xA3 with ld_valid held high → ld_done exactly 5 cycles after ld_start. Then fetch_addr 0..3 returns 0xA0..0xA3 at 1-cycle latency; fetch_data = 0 throughout hold.
- Gapped handshake: ld_len = 3, ld_valid toggling 1,0,0,1,0,1 → exactly 3 writes, ld_ready high throughout LOAD, ld_done one cycle after the third accepted beat.
- Boundaries:
  - ld_len = 0 → ld_done the next cycle, memory unchanged.
  - ld_len = 2^ADDR_W + 1 → ld_err = 1, no busy.
  - A following valid ld_start clears ld_err.
  - ld_len = 2^ADDR_W → the last word lands at address 2^ADDR_W - 1.
- Reset mid-load: rst after 2 of 4 beats → IDLE next cycle, no ld_done, addresses 0..1 hold the new words and 2..3 hold the old contents.
- ld_start asserted during LOAD → ignored: ld_len is not re-latched and the pointer does not reset.
